// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified 32x8 memory between the fetch unit (read-only) and the data unit.
// Each access runs IDLE -> ACCESS -> RESP. Define MEM_ARB_RR_EN for round-robin ties; otherwise D wins ties.
module mem_port_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t            state;
   state_t            state_next;
   logic              grant_d;
   logic              last_grant_d;
   logic              win_d;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;

   // Winner selection: a lone request always wins; a tie is resolved by the configured policy.
   always_comb begin
      grant_d = d_req;
      if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
         grant_d = ~last_grant_d;
`else
         grant_d = 1'b1;
`endif
      end
   end

`ifndef MEM_ARB_RR_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (if_req || d_req) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operands are captured only at the grant edge, so requesters may change them afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_d        <= 1'b0;
         last_grant_d <= 1'b0;
         lat_addr     <= '0;
         lat_we       <= 1'b0;
         lat_wdata    <= '0;
      end else if (state == IDLE && (if_req || d_req)) begin
         win_d        <= grant_d;
         last_grant_d <= grant_d;
         lat_addr     <= grant_d ? d_addr : if_addr;
         lat_we       <= grant_d & d_we;
         lat_wdata    <= grant_d ? d_wdata : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_rdata <= '0;
         d_rdata  <= '0;
      end else if (state == ACCESS && !lat_we) begin
         if (win_d) d_rdata  <= mem_rdata;
         else       if_rdata <= mem_rdata;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if_ack    = 1'b0;
      d_ack     = 1'b0;
      busy      = (state != IDLE);
      case (state)
         ACCESS: begin
            mem_addr  = lat_addr;
            mem_read  = ~lat_we;
            mem_write = lat_we;
            mem_wdata = lat_we ? lat_wdata : '0;
         end
         RESP: begin
            if_ack = ~win_d;
            d_ack  = win_d;
         end
         default: ;
      endcase
   end

endmodule
